// File: rtl/fft64_pkg.sv
// fft64_pkg: shared constants, state encoding and index helpers for the
// 64-point FFT frame scheduler.
package fft64_pkg;

  localparam int FFT_N = 64;
  localparam int LOG2N = 6;
  localparam int DW    = 16;

  // Index of the final sample in a frame.
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(FFT_N - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // The core emits bins in bit-reversed order; this maps a position in the
  // output stream back to its natural-order bin.
  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = {LOG2N{1'b0}};
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft64_tag_fifo.sv
// fft64_tag_fifo: small synchronous FIFO of 1-bit owner ids, one entry per
// frame that has been issued to the FFT core but not yet fully delivered.
module fft64_tag_fifo #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          push_data,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with wrap at DEPTH, so non-power-of-two depths work too.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    if (p == AW'(DEPTH - 1)) begin
      n = {AW{1'b0}};
    end else begin
      n = p + AW'(1);
    end
    return n;
  endfunction

  // Overflowing pushes and underflowing pops are ignored outright.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

  // Storage, pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fft64_frame_sched.sv
// fft64_frame_sched: grants a shared 64-point streaming FFT core to one of
// two requesters a whole frame at a time (round-robin), and tags each result
// sample with its owner and natural-order bin index.
module fft64_frame_sched
  import fft64_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rq0_valid,
  output logic             rq0_ready,
  input  logic [DW-1:0]    rq0_re,
  input  logic [DW-1:0]    rq0_im,
  input  logic             rq1_valid,
  output logic             rq1_ready,
  input  logic [DW-1:0]    rq1_re,
  input  logic [DW-1:0]    rq1_im,
  output logic             fft_di_en,
  output logic [DW-1:0]    fft_di_re,
  output logic [DW-1:0]    fft_di_im,
  input  logic             fft_do_en,
  input  logic [DW-1:0]    fft_do_re,
  input  logic [DW-1:0]    fft_do_im,
  output logic             out_valid,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic             out_tag,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             underrun,
  output logic             orphan
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  state_t           state_r;
  logic             grant_r;
  logic [LOG2N-1:0] in_cnt_r;
  logic             rr_ptr_r;
  logic [LOG2N-1:0] out_cnt_r;
  logic             frame_tag_r;
  logic             frame_orphan_r;

  logic             arb_s;
  logic             room_s;
  logic             el0_s;
  logic             el1_s;
  logic             win_valid_s;
  logic             win_id_s;
  logic             sel_valid_s;
  logic [DW-1:0]    sel_re_s;
  logic [DW-1:0]    sel_im_s;

  logic             push_s;
  logic             pop_s;
  logic             head_s;
  logic [CW-1:0]    count_s;
  logic             full_s;
  logic             empty_s;

  // Inflight frames are exactly the owner FIFO occupancy.
  assign room_s = (count_s < CW'(MAX_INFLIGHT));

  // Arbitration point detection and round-robin winner selection.
  always_comb begin
    arb_s       = 1'b0;
    el0_s       = 1'b0;
    el1_s       = 1'b0;
    win_valid_s = 1'b0;
    win_id_s    = 1'b0;
    if (state_r == IDLE) begin
      arb_s = 1'b1;
    end else if (in_cnt_r == LAST_IDX) begin
      arb_s = 1'b1;
    end else begin
      arb_s = 1'b0;
    end
    el0_s = arb_s && rq0_valid && room_s;
    el1_s = arb_s && rq1_valid && room_s;
    if (el0_s && el1_s) begin
      win_valid_s = 1'b1;
      win_id_s    = rr_ptr_r;
    end else if (el0_s) begin
      win_valid_s = 1'b1;
      win_id_s    = 1'b0;
    end else if (el1_s) begin
      win_valid_s = 1'b1;
      win_id_s    = 1'b1;
    end else begin
      win_valid_s = 1'b0;
      win_id_s    = 1'b0;
    end
  end

  // Route the granted requester's sample towards the core input register.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_re_s    = {DW{1'b0}};
    sel_im_s    = {DW{1'b0}};
    if (grant_r) begin
      sel_valid_s = rq1_valid;
      sel_re_s    = rq1_re;
      sel_im_s    = rq1_im;
    end else begin
      sel_valid_s = rq0_valid;
      sel_re_s    = rq0_re;
      sel_im_s    = rq0_im;
    end
  end

  // A sample is taken every STREAM cycle whether or not it is valid.
  assign rq0_ready = (state_r == STREAM) && !grant_r;
  assign rq1_ready = (state_r == STREAM) && grant_r;

  // The full guard is belt-and-braces: arbitration already requires room.
  assign push_s = win_valid_s && !full_s;
  // A frame that started orphaned owns no FIFO entry, so it must not pop one.
  assign pop_s  = fft_do_en && (out_cnt_r == LAST_IDX) && !frame_orphan_r;

  fft64_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (win_id_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Input-side FSM: stream 64 samples per grant, re-arbitrating on the last.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      grant_r   <= 1'b0;
      in_cnt_r  <= {LOG2N{1'b0}};
      rr_ptr_r  <= 1'b0;
      fft_di_en <= 1'b0;
      fft_di_re <= {DW{1'b0}};
      fft_di_im <= {DW{1'b0}};
      underrun  <= 1'b0;
    end else begin
      case (state_r)
        STREAM: begin
          fft_di_en <= 1'b1;
          in_cnt_r  <= in_cnt_r + LOG2N'(1);
          if (sel_valid_s) begin
            fft_di_re <= sel_re_s;
            fft_di_im <= sel_im_s;
            underrun  <= 1'b0;
          end else begin
            fft_di_re <= {DW{1'b0}};
            fft_di_im <= {DW{1'b0}};
            underrun  <= 1'b1;
          end
        end
        default: begin
          fft_di_en <= 1'b0;
          fft_di_re <= {DW{1'b0}};
          fft_di_im <= {DW{1'b0}};
          underrun  <= 1'b0;
        end
      endcase
      if (win_valid_s) begin
        state_r  <= STREAM;
        grant_r  <= win_id_s;
        rr_ptr_r <= ~win_id_s;
        in_cnt_r <= {LOG2N{1'b0}};
      end else if (arb_s) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Output side: register core results with owner tag and natural-order bin.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_cnt_r      <= {LOG2N{1'b0}};
      frame_tag_r    <= 1'b0;
      frame_orphan_r <= 1'b0;
      out_valid      <= 1'b0;
      out_re         <= {DW{1'b0}};
      out_im         <= {DW{1'b0}};
      out_tag        <= 1'b0;
      out_idx        <= {LOG2N{1'b0}};
      out_last       <= 1'b0;
      orphan         <= 1'b0;
    end else if (fft_do_en) begin
      out_cnt_r <= out_cnt_r + LOG2N'(1);
      out_valid <= 1'b1;
      out_re    <= fft_do_re;
      out_im    <= fft_do_im;
      out_idx   <= bit_rev(out_cnt_r);
      out_last  <= (out_cnt_r == LAST_IDX);
      if (out_cnt_r == {LOG2N{1'b0}}) begin
        if (empty_s) begin
          out_tag        <= 1'b0;
          orphan         <= 1'b1;
          frame_tag_r    <= 1'b0;
          frame_orphan_r <= 1'b1;
        end else begin
          out_tag        <= head_s;
          orphan         <= 1'b0;
          frame_tag_r    <= head_s;
          frame_orphan_r <= 1'b0;
        end
      end else begin
        out_tag <= frame_tag_r;
        orphan  <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      out_re    <= {DW{1'b0}};
      out_im    <= {DW{1'b0}};
      out_tag   <= 1'b0;
      out_idx   <= {LOG2N{1'b0}};
      out_last  <= 1'b0;
      orphan    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft64_frame_sched.sv
// tb_fft64_frame_sched: randomized bench with a frame-level reference model
// of the scheduler and a simple emulated FFT core driving fft_do_*.
module tb_fft64_frame_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        rq0_valid, rq1_valid;
  logic        rq0_ready, rq1_ready;
  logic [15:0] rq0_re, rq0_im, rq1_re, rq1_im;
  logic        fft_di_en;
  logic [15:0] fft_di_re, fft_di_im;
  logic        fft_do_en;
  logic [15:0] fft_do_re, fft_do_im;
  logic        out_valid, out_tag, out_last, underrun, orphan;
  logic [15:0] out_re, out_im;
  logic [5:0]  out_idx;

  always #5 clock = ~clock;

  fft64_frame_sched #(.MAX_INFLIGHT(4)) dut (
    .clock(clock), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_re(rq0_re), .rq0_im(rq0_im),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_re(rq1_re), .rq1_im(rq1_im),
    .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
    .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_tag(out_tag),
    .out_idx(out_idx), .out_last(out_last), .underrun(underrun), .orphan(orphan)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state (frame-level view of the scheduler).
  bit   m_busy, m_grant, m_forph, m_ftag, m_newframe;
  int   m_cnt, m_pref, m_ocnt, m_nwin;
  int   owners[$];
  // Expected registered outputs.
  bit          e_di_en, e_under, e_ovalid, e_otag, e_olast, e_orph;
  logic [15:0] e_di_re, e_di_im, e_ore, e_oim;
  int          e_oidx;

  // Emulated FFT core and bench observations.
  bit stall, gaps, force_do;
  int c_seen, c_ready, c_left;
  int cnt_di, cnt_out, cnt_last, cnt_under, cnt_orph, cnt_under_mid, cnt_zero_under;
  int cnt_nonzero_tag, di_run, di_max_run;
  int dut_grants[$];
  int dut_last_tags[$];

  function automatic int rev6(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 6; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic clear_obs();
    cnt_di = 0; cnt_out = 0; cnt_last = 0; cnt_under = 0; cnt_orph = 0;
    cnt_under_mid = 0; cnt_zero_under = 0; cnt_nonzero_tag = 0;
    di_run = 0; di_max_run = 0; m_nwin = 0;
    dut_grants.delete();
    dut_last_tags.delete();
  endtask

  // One clock: advance the model from the current inputs, clock, compare.
  task automatic step();
    int  infl, w;
    bit  arb, vg, el0, el1;
    m_newframe = 1'b0;
    if (reset) begin
      m_busy = 0; m_grant = 0; m_cnt = 0; m_pref = 0; m_ocnt = 0; m_ftag = 0; m_forph = 0;
      owners.delete();
      e_di_en = 0; e_di_re = 0; e_di_im = 0; e_under = 0;
      e_ovalid = 0; e_ore = 0; e_oim = 0; e_otag = 0; e_oidx = 0; e_olast = 0; e_orph = 0;
    end else begin
      infl = owners.size();
      arb  = !m_busy || (m_cnt == 63);
      if (m_busy) begin
        vg      = m_grant ? rq1_valid : rq0_valid;
        e_di_en = 1;
        e_di_re = vg ? (m_grant ? rq1_re : rq0_re) : 16'h0000;
        e_di_im = vg ? (m_grant ? rq1_im : rq0_im) : 16'h0000;
        e_under = !vg;
        m_cnt   = (m_cnt + 1) % 64;
      end else begin
        e_di_en = 0; e_di_re = 0; e_di_im = 0; e_under = 0;
      end
      if (fft_do_en) begin
        e_ovalid = 1; e_ore = fft_do_re; e_oim = fft_do_im;
        e_oidx   = rev6(m_ocnt);
        e_olast  = (m_ocnt == 63);
        e_orph   = 0;
        if (m_ocnt == 0) begin
          if (owners.size() == 0) begin
            m_ftag = 0; m_forph = 1; e_orph = 1;
          end else begin
            m_ftag = owners[0][0]; m_forph = 0;
          end
        end
        e_otag = m_ftag;
        if (m_ocnt == 63 && !m_forph && owners.size() > 0) void'(owners.pop_front());
        m_ocnt = (m_ocnt + 1) % 64;
      end else begin
        e_ovalid = 0; e_ore = 0; e_oim = 0; e_otag = 0; e_oidx = 0; e_olast = 0; e_orph = 0;
      end
      if (arb) begin
        el0 = rq0_valid && (infl < 4);
        el1 = rq1_valid && (infl < 4);
        w = -1;
        if (el0 && el1) w = m_pref;
        else if (el0) w = 0;
        else if (el1) w = 1;
        if (w >= 0) begin
          owners.push_back(w);
          m_grant = w[0]; m_pref = 1 - w; m_cnt = 0; m_busy = 1;
          m_nwin++; m_newframe = 1'b1;
        end else begin
          m_busy = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    check_val("di_en",     32'(fft_di_en), 32'(e_di_en));
    check_val("di_re",     32'(fft_di_re), 32'(e_di_re));
    check_val("di_im",     32'(fft_di_im), 32'(e_di_im));
    check_val("underrun",  32'(underrun),  32'(e_under));
    check_val("out_valid", 32'(out_valid), 32'(e_ovalid));
    check_val("out_re",    32'(out_re),    32'(e_ore));
    check_val("out_im",    32'(out_im),    32'(e_oim));
    check_val("out_tag",   32'(out_tag),   32'(e_otag));
    check_val("out_idx",   32'(out_idx),   32'(e_oidx));
    check_val("out_last",  32'(out_last),  32'(e_olast));
    check_val("orphan",    32'(orphan),    32'(e_orph));
    check_val("rq0_ready", 32'(rq0_ready), 32'(m_busy && !m_grant));
    check_val("rq1_ready", 32'(rq1_ready), 32'(m_busy && m_grant));
    // Bench-side observations of the DUT for scenario checks.
    if (fft_di_en) begin
      if (underrun && (cnt_di % 64) != 63) cnt_under_mid++;
      cnt_di++; di_run++;
      if (di_run > di_max_run) di_max_run = di_run;
    end else begin
      di_run = 0;
    end
    if (underrun) cnt_under++;
    if (underrun && fft_di_re == 16'h0000 && fft_di_im == 16'h0000) cnt_zero_under++;
    if (out_valid) cnt_out++;
    if (out_valid && out_tag) cnt_nonzero_tag++;
    if (out_valid && out_last) begin
      cnt_last++;
      dut_last_tags.push_back(int'(out_tag));
    end
    if (orphan) cnt_orph++;
    if (m_newframe) dut_grants.push_back(rq1_ready ? 1 : (rq0_ready ? 0 : -1));
    // Emulated FFT core: emits one 64-sample result frame per input frame.
    if (reset) begin
      c_seen = 0; c_ready = 0; c_left = 0;
    end else if (e_di_en) begin
      c_seen++;
      if (c_seen == 64) begin c_seen = 0; c_ready++; end
    end
    fft_do_re = 16'($urandom);
    fft_do_im = 16'($urandom);
    if (force_do) begin
      fft_do_en = 1'b1;
    end else begin
      if (c_left == 0 && c_ready > 0 && !stall) begin c_left = 64; c_ready--; end
      if (c_left > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        fft_do_en = 1'b1; c_left--;
      end else begin
        fft_do_en = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic rand_data();
    rq0_re = 16'($urandom); rq0_im = 16'($urandom);
    rq1_re = 16'($urandom); rq1_im = 16'($urandom);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    rq0_valid = 0; rq1_valid = 0;
    rq0_re = 0; rq0_im = 0; rq1_re = 0; rq1_im = 0;
    fft_do_en = 0; fft_do_re = 0; fft_do_im = 0;
    stall = 0; gaps = 0; force_do = 0;

    // Reset state (model expects all outputs zero, both ready low).
    repeat (3) step();
    reset = 1'b0;
    clear_obs();

    // Single rq0 frame of constant 0x000F/0x0000.
    rq0_re = 16'h000F; rq0_im = 16'h0000;
    for (int i = 0; i < 200; i++) begin
      rq0_valid = (!m_busy && m_nwin == 0) || (m_busy && m_cnt != 63);
      step();
    end
    check_val("single_di_cycles", 32'(cnt_di), 32'd64);
    check_val("single_di_run",    32'(di_max_run), 32'd64);
    check_val("single_out_cnt",   32'(cnt_out), 32'd64);
    check_val("single_last_cnt",  32'(cnt_last), 32'd1);
    check_val("single_tag_nz",    32'(cnt_nonzero_tag), 32'd0);

    // Both requesters continuously valid: four back-to-back frames.
    do_reset();
    for (int i = 0; i < 420; i++) begin
      rand_data();
      rq0_valid = (m_nwin < 4) || (m_busy && m_cnt != 63);
      rq1_valid = rq0_valid;
      step();
    end
    rq0_valid = 0; rq1_valid = 0;
    check_val("rr_grant_n", 32'(dut_grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("rr_grant", 32'(dut_grants.size() > i ? dut_grants[i] : -1), 32'(i % 2));
      check_val("rr_tag",   32'(dut_last_tags.size() > i ? dut_last_tags[i] : -1), 32'(i % 2));
    end
    check_val("rr_no_gap", 32'(di_max_run), 32'd256);

    // Stalled output: at most four frames in flight.
    do_reset();
    stall = 1;
    rq0_valid = 1; rq1_valid = 1;
    for (int i = 0; i < 340; i++) begin rand_data(); step(); end
    check_val("stall_grants", 32'(dut_grants.size()), 32'd4);
    check_val("stall_ready",  32'(rq0_ready | rq1_ready), 32'd0);
    check_val("stall_di_en",  32'(fft_di_en), 32'd0);
    stall = 0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (out_valid && out_last) seen = 1;
    end
    check_val("stall_pop_seen", 32'(seen), 32'd1);
    check_val("stall_ready_at_pop", 32'(rq0_ready | rq1_ready), 32'd0);
    step();
    check_val("stall_regrant_rq0", 32'(rq0_ready), 32'd1);
    rq0_valid = 0; rq1_valid = 0;
    repeat (600) step();

    // rq1 drops valid for three cycles mid-frame.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      rand_data();
      rq1_valid = ((!m_busy && m_nwin == 0) || (m_busy && m_cnt != 63))
                  && !(m_busy && m_cnt >= 20 && m_cnt <= 22);
      step();
    end
    rq1_valid = 0;
    check_val("under_mid_pulses", 32'(cnt_under_mid), 32'd3);
    check_val("under_zero_data",  32'(cnt_zero_under), 32'(cnt_under));
    check_val("under_frame_len",  32'(cnt_di), 32'd64);
    repeat (120) step();

    // Core output with no frame issued.
    do_reset();
    force_do = 1;
    repeat (64) step();
    force_do = 0;
    repeat (5) step();
    check_val("orphan_pulses", 32'(cnt_orph), 32'd1);
    check_val("orphan_outs",   32'(cnt_out), 32'd64);
    check_val("orphan_tag_nz", 32'(cnt_nonzero_tag), 32'd0);
    check_val("orphan_last",   32'(cnt_last), 32'd1);

    // Reset in the middle of a frame, then fresh arbitration prefers rq0.
    do_reset();
    rq0_valid = 1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      rand_data();
      if (m_busy && m_cnt == 30) seen = 1;
      else step();
    end
    check_val("midreset_reached", 32'(seen), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("midreset_ready", 32'(rq0_ready | rq1_ready), 32'd0);
    check_val("midreset_di_en", 32'(fft_di_en), 32'd0);
    rq0_valid = 1; rq1_valid = 1;
    step();
    check_val("midreset_grant_rq0", 32'(rq0_ready), 32'd1);
    check_val("midreset_grant_rq1", 32'(rq1_ready), 32'd0);

    // Random traffic with random output stalls and gaps.
    do_reset();
    gaps = 1;
    for (int i = 0; i < 2500; i++) begin
      rand_data();
      rq0_valid = ($urandom_range(0, 9) < 8);
      rq1_valid = ($urandom_range(0, 9) < 7);
      if (i % 200 == 0) stall = ($urandom_range(0, 3) == 0);
      step();
    end
    stall = 0; rq0_valid = 0; rq1_valid = 0;
    repeat (800) step();
    check_val("drain_fifo_empty", 32'(owners.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
